// File: rtl/mac_lookup_ctrl.sv
// MAC learn/lookup controller: learns the source MAC, looks up the
// destination MAC through an external search engine, and issues an egress
// port bitmap. It also launches periodic aging sweeps of the table.
module mac_lookup_ctrl #(
   parameter logic [31:0] AGING_PERIOD = 32'd50_000_000,
   parameter logic [7:0]  SE_TIMEOUT   = 8'd64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [47:0] req_smac,
   input  logic [47:0] req_dmac,
   input  logic [3:0]  req_inport,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [15:0] res_portmap,
   output logic        res_hit,
   output logic        se_source,
   output logic [47:0] se_mac,
   output logic [15:0] se_portmap,
   output logic [9:0]  se_hash,
   output logic        se_req,
   input  logic        se_ack,
   input  logic        se_nak,
   input  logic [15:0] se_result,
   output logic        aging_req,
   input  logic        aging_ack,
   output logic [15:0] learn_fail_cnt
);

   typedef enum logic [1:0] {S_IDLE, S_LEARN, S_LOOKUP, S_RESP} state_e;

   state_e      state_q, state_d;
   logic [47:0] dmac_q, dmac_d;
   logic [3:0]  inport_q, inport_d;
   logic        req_ready_q, req_ready_d;
   logic        res_valid_q, res_valid_d;
   logic [15:0] res_portmap_q, res_portmap_d;
   logic        res_hit_q, res_hit_d;
   logic        se_req_q, se_req_d;
   logic        se_source_q, se_source_d;
   logic [47:0] se_mac_q, se_mac_d;
   logic [15:0] se_portmap_q, se_portmap_d;
   logic [9:0]  se_hash_q, se_hash_d;
   logic [7:0]  to_cnt_q, to_cnt_d;
   logic [15:0] fail_cnt_q, fail_cnt_d;
   logic [31:0] timer_q, timer_d;
   logic        aging_pending_q, aging_pending_d;

   logic        se_resp, se_done, se_ack_ok, se_timeout;
   logic [15:0] own_mask;

   function automatic logic [9:0] mac_hash(input logic [47:0] mac);
      return mac[9:0] ^ mac[19:10] ^ mac[29:20] ^ mac[39:30] ^ {2'b0, mac[47:40]};
   endfunction

   // Search handshake decode; responses only count while se_req is high,
   // and ack together with nak is treated as nak.
   always_comb begin
      se_resp    = se_req_q & (se_ack | se_nak);
      se_timeout = se_req_q & ~se_resp & (to_cnt_q == SE_TIMEOUT - 8'd1);
      se_done    = se_resp | se_timeout;
      se_ack_ok  = se_resp & se_ack & ~se_nak;
      own_mask   = 16'h0001 << inport_q;
   end

   // Transaction FSM: next state and next values of all registered outputs.
   always_comb begin
      state_d       = state_q;
      dmac_d        = dmac_q;
      inport_d      = inport_q;
      res_valid_d   = res_valid_q;
      res_portmap_d = res_portmap_q;
      res_hit_d     = res_hit_q;
      se_req_d      = se_req_q;
      se_source_d   = se_source_q;
      se_mac_d      = se_mac_q;
      se_portmap_d  = se_portmap_q;
      se_hash_d     = se_hash_q;
      to_cnt_d      = to_cnt_q;
      fail_cnt_d    = fail_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_valid && req_ready_q) begin
               dmac_d   = req_dmac;
               inport_d = req_inport;
               if (!req_smac[40]) begin
                  state_d      = S_LEARN;
                  se_source_d  = 1'b1;
                  se_mac_d     = req_smac;
                  se_portmap_d = 16'h0001 << req_inport;
                  se_hash_d    = mac_hash(req_smac);
               end else begin
                  state_d      = S_LOOKUP;
                  se_source_d  = 1'b0;
                  se_mac_d     = req_dmac;
                  se_portmap_d = '0;
                  se_hash_d    = mac_hash(req_dmac);
               end
            end
         end
         S_LEARN: begin
            if (!se_req_q) begin
               se_req_d = 1'b1;
               to_cnt_d = '0;
            end else if (se_done) begin
               se_req_d     = 1'b0;
               state_d      = S_LOOKUP;
               se_source_d  = 1'b0;
               se_mac_d     = dmac_q;
               se_portmap_d = '0;
               se_hash_d    = mac_hash(dmac_q);
               if (!se_ack_ok && fail_cnt_q != 16'hFFFF)
                  fail_cnt_d = fail_cnt_q + 16'd1;
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         S_LOOKUP: begin
            // se_req low here means the first LOOKUP cycle: group
            // destinations flood at once, unicast ones start a search.
            if (!se_req_q) begin
               if (dmac_q[40]) begin
                  state_d       = S_RESP;
                  res_valid_d   = 1'b1;
                  res_portmap_d = ~own_mask;
                  res_hit_d     = 1'b0;
               end else begin
                  se_req_d = 1'b1;
                  to_cnt_d = '0;
               end
            end else if (se_done) begin
               se_req_d    = 1'b0;
               state_d     = S_RESP;
               res_valid_d = 1'b1;
               if (se_ack_ok) begin
                  res_portmap_d = se_result & ~own_mask;
                  res_hit_d     = 1'b1;
               end else begin
                  res_portmap_d = ~own_mask;
                  res_hit_d     = 1'b0;
               end
            end else begin
               to_cnt_d = to_cnt_q + 8'd1;
            end
         end
         S_RESP: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
      endcase
      req_ready_d = (state_d == S_IDLE);
   end

   // Aging timer: free-running reload counter; an expiry while a sweep is
   // still pending is dropped.
   always_comb begin
      timer_d         = (timer_q == '0) ? AGING_PERIOD - 32'd1 : timer_q - 32'd1;
      aging_pending_d = aging_pending_q;
      if (timer_q == '0 && !aging_pending_q)
         aging_pending_d = 1'b1;
      else if (aging_ack)
         aging_pending_d = 1'b0;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= S_IDLE;
         dmac_q          <= '0;
         inport_q        <= '0;
         req_ready_q     <= 1'b0;
         res_valid_q     <= 1'b0;
         res_portmap_q   <= '0;
         res_hit_q       <= 1'b0;
         se_req_q        <= 1'b0;
         se_source_q     <= 1'b0;
         se_mac_q        <= '0;
         se_portmap_q    <= '0;
         se_hash_q       <= '0;
         to_cnt_q        <= '0;
         fail_cnt_q      <= '0;
         timer_q         <= AGING_PERIOD - 32'd1;
         aging_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         dmac_q          <= dmac_d;
         inport_q        <= inport_d;
         req_ready_q     <= req_ready_d;
         res_valid_q     <= res_valid_d;
         res_portmap_q   <= res_portmap_d;
         res_hit_q       <= res_hit_d;
         se_req_q        <= se_req_d;
         se_source_q     <= se_source_d;
         se_mac_q        <= se_mac_d;
         se_portmap_q    <= se_portmap_d;
         se_hash_q       <= se_hash_d;
         to_cnt_q        <= to_cnt_d;
         fail_cnt_q      <= fail_cnt_d;
         timer_q         <= timer_d;
         aging_pending_q <= aging_pending_d;
      end
   end

   assign req_ready      = req_ready_q;
   assign res_valid      = res_valid_q;
   assign res_portmap    = res_portmap_q;
   assign res_hit        = res_hit_q;
   assign se_req         = se_req_q;
   assign se_source      = se_source_q;
   assign se_mac         = se_mac_q;
   assign se_portmap     = se_portmap_q;
   assign se_hash        = se_hash_q;
   assign aging_req      = aging_pending_q;
   assign learn_fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_mac_lookup_ctrl.sv
// Bench for mac_lookup_ctrl: directed scenarios plus randomized
// transactions checked against a behavioural model of the forwarding rules.
module tb_mac_lookup_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [47:0] req_smac = '0;
   logic [47:0] req_dmac = '0;
   logic [3:0]  req_inport = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [15:0] res_portmap;
   logic        res_hit;
   logic        se_source;
   logic [47:0] se_mac;
   logic [15:0] se_portmap;
   logic [9:0]  se_hash;
   logic        se_req;
   logic        se_ack = 1'b0;
   logic        se_nak = 1'b0;
   logic [15:0] se_result = '0;
   logic        aging_req;
   logic        aging_ack = 1'b0;
   logic [15:0] learn_fail_cnt;

   int checks = 0;
   int failures = 0;
   int exp_fail = 0;

   mac_lookup_ctrl #(.AGING_PERIOD(32'd100), .SE_TIMEOUT(8'd64)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_smac(req_smac), .req_dmac(req_dmac), .req_inport(req_inport),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_portmap(res_portmap), .res_hit(res_hit),
      .se_source(se_source), .se_mac(se_mac), .se_portmap(se_portmap),
      .se_hash(se_hash), .se_req(se_req), .se_ack(se_ack), .se_nak(se_nak),
      .se_result(se_result),
      .aging_req(aging_req), .aging_ack(aging_ack),
      .learn_fail_cnt(learn_fail_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Fold the MAC into 10-bit chunks and XOR them together.
   function automatic logic [9:0] ref_hash(input logic [47:0] mac);
      logic [47:0] m = mac;
      logic [9:0]  h = '0;
      for (int i = 0; i < 5; i++) begin
         h = h ^ m[9:0];
         m = m >> 10;
      end
      return h;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_fail = 0;
   endtask

   // Plays the search engine for one request: checks the operands on every
   // cycle se_req is high and answers after 'delay' cycles (mode 0 ack,
   // 1 nak, 2 ack+nak, 3 silent).
   task automatic serve(input logic exp_src, input logic [47:0] exp_mac,
                        input logic [15:0] exp_map, input int mode, input int delay,
                        input logic [15:0] result, input string tag);
      int wait_cyc = 0;
      int high = 0;
      int exp_high;
      while (se_req !== 1'b1 && wait_cyc < 8) begin
         @(negedge clk);
         wait_cyc++;
      end
      checks++;
      if (se_req !== 1'b1 || wait_cyc != 1) begin
         failures++;
         $display("FAIL %s_se_req_rise: se_req=%b after %0d cycles, required 1 after 1",
                  tag, se_req, wait_cyc);
      end
      while (se_req === 1'b1 && high < 100) begin
         checks++;
         if (se_source !== exp_src || se_mac !== exp_mac || se_portmap !== exp_map ||
             se_hash !== ref_hash(exp_mac)) begin
            failures++;
            $display("FAIL %s_operands: src=%b mac=%h map=%h hash=%h required src=%b mac=%h map=%h hash=%h",
                     tag, se_source, se_mac, se_portmap, se_hash,
                     exp_src, exp_mac, exp_map, ref_hash(exp_mac));
         end
         if (mode != 3 && high == delay) begin
            se_ack    = (mode == 0 || mode == 2);
            se_nak    = (mode == 1 || mode == 2);
            se_result = result;
         end else begin
            se_ack    = 1'b0;
            se_nak    = 1'b0;
            se_result = 16'($urandom);
         end
         high++;
         @(negedge clk);
      end
      se_ack = 1'b0;
      se_nak = 1'b0;
      exp_high = (mode == 3) ? 64 : delay + 1;
      checks++;
      if (high != exp_high) begin
         failures++;
         $display("FAIL %s_se_req_len: se_req high %0d cycles, required %0d", tag, high, exp_high);
      end
   endtask

   // One full header: accept, learn/lookup phases, result, backpressure for
   // 'hold' cycles (optionally with a stray ack), then release.
   task automatic run_txn(input logic [47:0] smac, input logic [47:0] dmac,
                          input logic [3:0] inport, input int lmode, input int ldelay,
                          input int kmode, input int kdelay, input logic [15:0] result,
                          input int hold, input bit late_ack, input string tag);
      logic [15:0] own = 16'h0001 << inport;
      logic [15:0] exp_map;
      logic        exp_hit;
      int n = 0;
      int stray = 0;
      while (req_ready !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_req_ready_idle: req_ready=%b required 1", tag, req_ready);
      end
      req_valid  = 1'b1;
      req_smac   = smac;
      req_dmac   = dmac;
      req_inport = inport;
      @(negedge clk);
      req_valid  = 1'b0;
      req_smac   = {16'($urandom), 32'($urandom)};
      req_dmac   = {16'($urandom), 32'($urandom)};
      req_inport = 4'($urandom);
      checks++;
      if (req_ready !== 1'b0) begin
         failures++;
         $display("FAIL %s_req_ready_busy: req_ready=%b required 0", tag, req_ready);
      end
      if (!smac[40]) begin
         serve(1'b1, smac, own, lmode, ldelay, 16'($urandom), {tag, "_learn"});
         if (lmode != 0 && exp_fail < 65535) exp_fail++;
      end
      if (!dmac[40]) begin
         serve(1'b0, dmac, 16'h0000, kmode, kdelay, result, {tag, "_lookup"});
         if (kmode == 0) begin
            exp_map = result & ~own;
            exp_hit = 1'b1;
         end else begin
            exp_map = ~own;
            exp_hit = 1'b0;
         end
      end else begin
         exp_map = ~own;
         exp_hit = 1'b0;
      end
      n = 0;
      while (res_valid !== 1'b1 && n < 10) begin
         if (se_req === 1'b1) stray++;
         @(negedge clk);
         n++;
      end
      checks++;
      if (res_valid !== 1'b1 || stray != 0) begin
         failures++;
         $display("FAIL %s_res_valid: res_valid=%b stray_se_req=%0d required 1 and 0",
                  tag, res_valid, stray);
      end
      checks++;
      if (res_portmap !== exp_map || res_hit !== exp_hit) begin
         failures++;
         $display("FAIL %s_result: portmap=%h hit=%b required portmap=%h hit=%b",
                  tag, res_portmap, res_hit, exp_map, exp_hit);
      end
      checks++;
      if (learn_fail_cnt !== 16'(exp_fail)) begin
         failures++;
         $display("FAIL %s_fail_cnt: learn_fail_cnt=%0d required %0d", tag, learn_fail_cnt, exp_fail);
      end
      for (int i = 0; i < hold; i++) begin
         se_ack    = late_ack && (i == 1);
         se_result = 16'($urandom);
         @(negedge clk);
         checks++;
         if (res_valid !== 1'b1 || res_portmap !== exp_map || res_hit !== exp_hit ||
             req_ready !== 1'b0 || se_req !== 1'b0) begin
            failures++;
            $display("FAIL %s_hold: valid=%b map=%h hit=%b req_ready=%b se_req=%b required 1 %h %b 0 0",
                     tag, res_valid, res_portmap, res_hit, req_ready, se_req, exp_map, exp_hit);
         end
      end
      se_ack    = 1'b0;
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      checks++;
      if (res_valid !== 1'b0 || req_ready !== 1'b1) begin
         failures++;
         $display("FAIL %s_release: res_valid=%b req_ready=%b required 0 1", tag, res_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || res_valid !== 1'b0 || res_portmap !== 16'h0 || res_hit !== 1'b0 ||
          se_req !== 1'b0 || se_source !== 1'b0 || se_mac !== 48'h0 || se_portmap !== 16'h0 ||
          se_hash !== 10'h0 || aging_req !== 1'b0 || learn_fail_cnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_state: rdy=%b val=%b map=%h hit=%b req=%b src=%b mac=%h smap=%h hash=%h age=%b cnt=%h required all 0",
                  req_ready, res_valid, res_portmap, res_hit, se_req, se_source, se_mac,
                  se_portmap, se_hash, aging_req, learn_fail_cnt);
      end
      rst = 1'b0;
      exp_fail = 0;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_req_ready: req_ready=%b required 1", req_ready);
      end
   endtask

   task automatic test_unicast_ack();
      run_txn(48'h001122334455, 48'h00AABBCCDDEE, 4'd3, 0, 2, 0, 1, 16'h0021, 0, 1'b0, "unicast_ack");
      run_txn(48'h001122334455, 48'h00AABBCCDDEE, 4'd0, 0, 0, 0, 0, 16'h0001, 0, 1'b0, "same_port");
   endtask

   task automatic test_broadcast();
      run_txn(48'h001122334455, 48'hFFFFFFFFFFFF, 4'd0, 0, 1, 0, 0, 16'h0, 0, 1'b0, "bcast_learn");
      run_txn(48'h01005E000001, 48'hFFFFFFFFFFFF, 4'd0, 0, 0, 0, 0, 16'h0, 0, 1'b0, "bcast_nolearn");
   endtask

   task automatic test_nak();
      run_txn(48'h0A0B0C0D0E0F, 48'h102030405060, 4'd15, 1, 1, 1, 2, 16'h1234, 0, 1'b0, "nak");
      run_txn(48'h0A0B0C0D0E0F, 48'h102030405060, 4'd7, 2, 0, 2, 0, 16'hFFFF, 0, 1'b0, "ack_and_nak");
   endtask

   task automatic test_timeout();
      run_txn(48'h3C3C3C3C3C3C, 48'h567890ABCDEF, 4'd5, 0, 0, 3, 0, 16'hBEEF, 4, 1'b1, "lookup_timeout");
      run_txn(48'h3C3C3C3C3C3C, 48'h567890ABCDEF, 4'd9, 3, 0, 0, 1, 16'h0F0F, 0, 1'b0, "learn_timeout");
   endtask

   task automatic test_back_to_back();
      run_txn(48'h001122334455, 48'h00AABBCCDDEE, 4'd2, 0, 0, 0, 0, 16'h8421, 10, 1'b0, "backpressure");
      run_txn(48'h00A1A2A3A4A5, 48'h00B1B2B3B4B5, 4'd11, 0, 0, 0, 0, 16'hF00F, 0, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_in_resp();
      int n = 0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_smac   = 48'h01005E000002;
      req_dmac   = 48'hFFFFFFFFFFFF;
      req_inport = 4'd4;
      @(negedge clk);
      req_valid = 1'b0;
      while (res_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_fail = 0;
      checks++;
      if (res_valid !== 1'b0 || res_portmap !== 16'h0 || se_req !== 1'b0 || n >= 10) begin
         failures++;
         $display("FAIL reset_in_resp: res_valid=%b res_portmap=%h se_req=%b wait=%0d required 0 0 0 <10",
                  res_valid, res_portmap, se_req, n);
      end
   endtask

   task automatic test_random();
      for (int t = 0; t < 30; t++) begin
         int r;
         int lm;
         int km;
         r  = int'($urandom_range(0, 15));
         lm = (r < 10) ? 0 : (r < 13) ? 1 : (r < 15) ? 2 : 3;
         r  = int'($urandom_range(0, 15));
         km = (r < 10) ? 0 : (r < 13) ? 1 : (r < 15) ? 2 : 3;
         run_txn({16'($urandom), 32'($urandom)}, {16'($urandom), 32'($urandom)},
                 4'($urandom), lm, int'($urandom_range(0, 4)), km, int'($urandom_range(0, 4)),
                 16'($urandom), int'($urandom_range(0, 3)), 1'b0, "random");
      end
   endtask

   // Expiries fall every 100 cycles after reset; the one at 200 arrives
   // while still pending and must vanish, so only 300 raises it again.
   task automatic test_aging();
      do_reset();
      for (int k = 1; k <= 305; k++) begin
         logic exp_req;
         @(negedge clk);
         exp_req = (k >= 100 && k <= 249) || k >= 300;
         checks++;
         if (aging_req !== exp_req) begin
            failures++;
            $display("FAIL aging_req_cycle_%0d: aging_req=%b required %b", k, aging_req, exp_req);
         end
         aging_ack = (k == 249);
      end
      aging_ack = 1'b0;
   endtask

   initial begin
      test_reset();
      test_unicast_ack();
      test_broadcast();
      test_nak();
      test_timeout();
      test_back_to_back();
      test_reset_in_resp();
      test_random();
      test_aging();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac_lookup_ctrl.md
MAC_LOOKUP_CTRL -- requirements
Module: mac_lookup_ctrl

Interface
REQ-001 The block SHALL have parameter AGING_PERIOD, default 32'd50_000_000, meaning clk cycles between aging sweep launches.
REQ-002 The block SHALL have parameter SE_TIMEOUT, default 8'd64, meaning maximum cycles to wait for se_ack/se_nak.
REQ-003 The block SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, meaning synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1, meaning a frame header is offered.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the header is accepted when req_valid&req_ready.
REQ-007 The block SHALL have port req_smac, input, 48, meaning source MAC.
REQ-008 The block SHALL have port req_dmac, input, 48, meaning destination MAC.
REQ-009 The block SHALL have port req_inport, input, 4, meaning ingress port index 0..15.
REQ-010 The block SHALL have port res_valid, output, 1, meaning a forwarding result is present.
REQ-011 The block SHALL have port res_ready, input, 1, meaning the consumer takes the result.
REQ-012 The block SHALL have port res_portmap, output, 16, meaning egress port bitmap.
REQ-013 The block SHALL have port res_hit, output, 1, meaning the destination was found in the table.
REQ-014 The block SHALL have port se_source, output, 1, meaning 1 = learn, 0 = lookup.
REQ-015 The block SHALL have ports se_mac (output, 48), se_portmap (output, 16) and se_hash (output, 10), meaning the search operands.
REQ-016 The block SHALL have ports se_req (output, 1), se_ack (input, 1), se_nak (input, 1) and se_result (input, 16), meaning the search handshake.
REQ-017 The block SHALL have ports aging_req (output, 1) and aging_ack (input, 1), meaning the aging sweep handshake.
REQ-018 The block SHALL have port learn_fail_cnt, output, 16, meaning a saturating count of learn naks and timeouts.

Function
REQ-019 Hash SHALL be mac[9:0]^mac[19:10]^mac[29:20]^mac[39:30]^{2'b0,mac[47:40]}, with the same function used for learn and lookup.
REQ-020 The FSM SHALL have states IDLE, LEARN, LOOKUP and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, on accept, the block SHALL register smac/dmac/inport; it SHALL go to LEARN if smac[40]==0, else to LOOKUP.
REQ-022 In LEARN, se_source=1, se_mac=smac, se_portmap=1<<inport and se_hash=hash(smac).
REQ-023 In LOOKUP, se_source=0, se_mac=dmac, se_portmap=0 and se_hash=hash(dmac).
REQ-024 se_req SHALL rise on the cycle after entering LEARN/LOOKUP and stay high until the first cycle se_ack or se_nak is sampled 1, then drop on the next edge.
REQ-025 All se_* operands SHALL be held stable while se_req is high and on the ack/nak cycle.
REQ-026 If se_ack and se_nak are both 1, the block SHALL treat the event as nak.
REQ-027 In LEARN, on ack, nak or timeout (SE_TIMEOUT cycles with se_req high and no response), the block SHALL go to LOOKUP; nak/timeout SHALL increment learn_fail_cnt, saturating at 16'hFFFF.
REQ-028 The block SHALL enter LOOKUP directly, with no se_req, when dmac[40]==1 (broadcast/multicast): res_portmap=16'hFFFF & ~(1<<inport), res_hit=0, then RESP.
REQ-029 In LOOKUP, on ack: res_portmap=se_result & ~(1<<inport), res_hit=1; a zero map (same-port destination) SHALL be delivered as is.
REQ-030 In LOOKUP, on nak/timeout: res_portmap=16'hFFFF & ~(1<<inport), res_hit=0 (flood).
REQ-031 In RESP, res_valid SHALL be 1 and res_portmap/res_hit SHALL be held; on res_valid&res_ready the block SHALL return to IDLE.
REQ-032 The aging timer SHALL be a 32-bit down counter reloaded with AGING_PERIOD-1; on reaching 0 it SHALL set aging_pending and reload.
REQ-033 aging_req SHALL equal aging_pending; aging_pending SHALL be cleared on the edge aging_ack is sampled 1.
REQ-034 A timer expiry while aging_pending is already set SHALL be dropped, with no queueing.
REQ-035 aging_req SHALL be independent of the FSM; the downstream table gives se_req priority.
REQ-036 A late se_ack/se_nak arriving after a timeout, while se_req is low, SHALL be ignored.

Reset
REQ-037 On rst=1 at a clock edge: FSM=IDLE; req_ready=0 during reset, then 1; res_valid=0; res_portmap=0; res_hit=0; se_req=0; se_source=0; se_mac=0; se_portmap=0; se_hash=0; aging_req=0; learn_fail_cnt=0; timer=AGING_PERIOD-1.
REQ-038 Reset mid-transaction SHALL abort it with no result produced; the downstream table completes any operation in flight independently.

Verification
REQ-039 The bench SHALL cover: smac=00:11:22:33:44:55, inport=3, learn ack, dmac unicast ack with se_result=16'h0021 -> se_portmap=16'h0008 in LEARN, res_portmap=16'h0021, res_hit=1.
REQ-040 The bench SHALL cover: dmac=FF:FF:FF:FF:FF:FF, inport=0 -> no lookup se_req, res_portmap=16'hFFFE, res_hit=0.
REQ-041 The bench SHALL cover: learn nak, lookup nak, inport=15 -> learn_fail_cnt+1, res_portmap=16'h7FFF, res_hit=0.
REQ-042 The bench SHALL cover: no se_ack/se_nak for 64 cycles in LOOKUP -> se_req drops, flood result issued, late ack ignored.
REQ-043 The bench SHALL cover: AGING_PERIOD=100 -> aging_req rises after 100 cycles, held until aging_ack pulse, falls next edge; no second expiry queued.
REQ-044 The bench SHALL cover: res_ready=0 for 10 cycles -> res_valid/res_portmap stable, req_ready=0; rst asserted in RESP -> res_valid=0 next cycle.
